// File: rtl/dpram_stream_reader_pkg.sv
// Shared FSM encoding and sizing constants for the port-B stream reader.
package dpram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 4;
    localparam int RD_LAT     = 2;
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH) + 1;

endpackage

// File: rtl/dpram_stream_reader_if.sv
// RAM port-B bus plus outgoing valid/ready stream.
interface dpram_stream_reader_if #(
    parameter int DEPTH = 256
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] o_PortB_Addr16;
    logic              o_PortB_WE;
    logic [15:0]       o_PortB_Data;
    logic [15:0]       i_PortB_Data;
    logic [15:0]       o_Stream_Data;
    logic              o_Stream_DV;
    logic              i_Stream_Ready;

    modport master (
        output o_PortB_Addr16, o_PortB_WE, o_PortB_Data,
        output o_Stream_Data, o_Stream_DV,
        input  i_PortB_Data, i_Stream_Ready
    );

    modport slave (
        input  o_PortB_Addr16, o_PortB_WE, o_PortB_Data,
        input  o_Stream_Data, o_Stream_DV,
        output i_PortB_Data, i_Stream_Ready
    );

endinterface

// File: rtl/dpram_stream_reader_stream_fifo.sv
// Width x depth synchronous FIFO; head comes straight from storage flops.
module stream_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_pop;

    assign do_pop = pop_i && (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (do_pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Reads a run of words from RAM port B and streams them out with credit flow control.
module dpram_stream_reader
    import dpram_stream_reader_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Bus_Clk,
    input  logic              i_Bus_Rst,
    input  logic              i_Start,
    input  logic [ADDR_W-1:0] i_Start_Addr16,
    input  logic [ADDR_W:0]   i_Length,
    output logic              o_Busy,
    output logic              o_Done,
    dpram_stream_reader_if.master bus
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [RD_LAT-2:0]   infl_q, infl_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [FIFO_CW-1:0]  fifo_cnt;
    logic [15:0]         fifo_head;
    logic                dv, push, pop, issue, drained;
    logic [3:0]          occ;

    assign dv   = fifo_cnt != '0;
    assign pop  = dv && bus.i_Stream_Ready;
    assign push = infl_q[RD_LAT-2];

    // Words held plus words still in the RAM pipe, net of this cycle's pop.
    assign occ     = 4'(fifo_cnt) + 4'($countones(infl_q)) - 4'(pop);
    assign issue   = (state_q == ST_RUN) && (occ < 4'(FIFO_DEPTH));
    assign drained = (infl_q == '0) && (fifo_cnt == FIFO_CW'(pop));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        infl_d  = (RD_LAT-1)'({infl_q, issue});
        unique case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    busy_d = 1'b1;
                    if (i_Length == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                        addr_d  = i_Start_Addr16;
                        rem_d   = i_Length;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Bus_Clk) begin
        if (i_Bus_Rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            infl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            infl_q  <= infl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    stream_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_Bus_Clk),
        .rst_i   (i_Bus_Rst),
        .push_i  (push),
        .data_i  (bus.i_PortB_Data),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    assign o_Busy             = busy_q;
    assign o_Done             = done_q;
    assign bus.o_PortB_Addr16 = addr_q;
    assign bus.o_PortB_WE     = 1'b0;
    assign bus.o_PortB_Data   = '0;
    assign bus.o_Stream_Data  = fifo_head;
    assign bus.o_Stream_DV    = dv;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: tabulated runs, reset corner and random runs vs a RAM-array model.
module tb_dpram_stream_reader;

    localparam int DEPTH = 256;

    typedef struct {
        int          a;
        int          len;
        int          mode;
        int          inject;
        int          exp_first;
        int          exp_done;
        logic [15:0] exp_w0;
        logic [15:0] exp_wl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  length;
    logic        busy;
    logic        done;
    logic [15:0] mem [DEPTH];
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        tbl [7];

    dpram_stream_reader_if #(.DEPTH(DEPTH)) bus ();

    dpram_stream_reader #(.DEPTH(DEPTH)) dut (
        .i_Bus_Clk      (clk),
        .i_Bus_Rst      (rst),
        .i_Start        (start),
        .i_Start_Addr16 (start_addr),
        .i_Length       (length),
        .o_Busy         (busy),
        .o_Done         (done),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.i_PortB_Data <= mem[bus.o_PortB_Addr16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run(input int a, input int len, input int mode, input int inject,
                       output int first_dv, output int done_cyc,
                       output logic [15:0] w0, output logic [15:0] wl);
        int          cyc, beats, last_beat, budget;
        logic        stall;
        logic [15:0] held;
        logic [7:0]  addr0;
        first_dv  = -1;
        done_cyc  = -1;
        beats     = 0;
        last_beat = -1;
        stall     = 1'b0;
        held      = '0;
        w0        = '0;
        wl        = '0;
        budget    = 4 * len + 40;
        @(negedge clk);
        addr0      = bus.o_PortB_Addr16;
        start      = 1'b1;
        start_addr = a[7:0];
        length     = len[8:0];
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (len != 0) chk("addr_cycle1", 32'(bus.o_PortB_Addr16), 32'(a));
        while (cyc <= budget) begin
            case (mode)
                0:       bus.i_Stream_Ready = 1'b1;
                1:       bus.i_Stream_Ready = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: bus.i_Stream_Ready = ($urandom_range(0, 3) != 0);
            endcase
            if (stall) begin
                chk("stall_dv", 32'(bus.o_Stream_DV), 32'd1);
                chk("stall_data", 32'(bus.o_Stream_Data), 32'(held));
            end
            if (bus.o_Stream_DV && first_dv < 0) first_dv = cyc;
            if (bus.o_Stream_DV && bus.i_Stream_Ready) begin
                chk($sformatf("beat%0d", beats), 32'(bus.o_Stream_Data),
                    32'(mem[(a + beats) % DEPTH]));
                if (beats == 0) w0 = bus.o_Stream_Data;
                wl        = bus.o_Stream_Data;
                beats++;
                last_beat = cyc;
            end
            stall = bus.o_Stream_DV && !bus.i_Stream_Ready;
            held  = bus.o_Stream_Data;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (len == 0) chk("zero_len_addr", 32'(bus.o_PortB_Addr16), 32'(addr0));
            if (inject != 0 && cyc == 5) begin
                start      = 1'b1;
                start_addr = 8'd100;
                length     = 9'd2;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (done_cyc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_timeout: got no done, want done within %0d cycles", budget);
        end
        chk("beat_count", 32'(beats), 32'(len));
        if (len != 0) chk("done_after_last", 32'(done_cyc), 32'(last_beat + 1));
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("dv_after_done", 32'(bus.o_Stream_DV), 32'd0);
    endtask

    initial begin
        int          f, d;
        logic [15:0] w0, wl;
        rst                = 1'b1;
        start              = 1'b0;
        start_addr         = '0;
        length             = '0;
        bus.i_Stream_Ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hA000 + 16'(i);

        tbl[0] = '{0,   8,   0, 0, 3,  11,  16'hA000, 16'hA007};
        tbl[1] = '{254, 4,   0, 0, 3,  7,   16'hA0FE, 16'hA001};
        tbl[2] = '{0,   16,  1, 0, 3,  0,   16'hA000, 16'hA00F};
        tbl[3] = '{0,   0,   0, 0, -1, 2,   16'h0000, 16'h0000};
        tbl[4] = '{10,  6,   0, 1, 3,  9,   16'hA00A, 16'hA00F};
        tbl[5] = '{0,   256, 0, 0, 3,  259, 16'hA000, 16'hA0FF};
        tbl[6] = '{250, 12,  1, 0, 3,  0,   16'hA0FA, 16'hA005};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dv", 32'(bus.o_Stream_DV), 32'd0);
        chk("rst_data", 32'(bus.o_Stream_Data), 32'd0);
        chk("rst_addr", 32'(bus.o_PortB_Addr16), 32'd0);
        chk("rst_we", 32'(bus.o_PortB_WE), 32'd0);
        chk("rst_wdata", 32'(bus.o_PortB_Data), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            run(tbl[k].a, tbl[k].len, tbl[k].mode, tbl[k].inject, f, d, w0, wl);
            chk($sformatf("t%0d_first_dv", k), 32'(f), 32'(tbl[k].exp_first));
            if (tbl[k].exp_done != 0)
                chk($sformatf("t%0d_done_cyc", k), 32'(d), 32'(tbl[k].exp_done));
            if (tbl[k].len != 0) begin
                chk($sformatf("t%0d_first_word", k), 32'(w0), 32'(tbl[k].exp_w0));
                chk($sformatf("t%0d_last_word", k), 32'(wl), 32'(tbl[k].exp_wl));
            end
        end

        @(negedge clk);
        start              = 1'b1;
        start_addr         = 8'd20;
        length             = 9'd10;
        bus.i_Stream_Ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_beat3", 32'(bus.o_Stream_Data), 32'h0000A016);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dv", 32'(bus.o_Stream_DV), 32'd0);
        chk("midrst_data", 32'(bus.o_Stream_Data), 32'd0);
        chk("midrst_addr", 32'(bus.o_PortB_Addr16), 32'd0);
        chk("midrst_we", 32'(bus.o_PortB_WE), 32'd0);
        chk("midrst_wdata", 32'(bus.o_PortB_Data), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("postrst_dv", 32'(bus.o_Stream_DV), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
        end
        run(5, 2, 0, 0, f, d, w0, wl);
        chk("rerun_first", 32'(f), 32'd3);
        chk("rerun_w0", 32'(w0), 32'h0000A005);
        chk("rerun_w1", 32'(wl), 32'h0000A006);

        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        for (int t = 0; t < 25; t++) begin
            run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 48)), 2,
                int'($urandom_range(0, 1)), f, d, w0, wl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
